mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W SHALL default to 32; it is the data and address width.
REQ-002 Parameter LEN_W SHALL default to 3; it is the burst-length field width.
REQ-003 clk_i  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 mN_req_valid/mN_req_ready  in/out  1  request handshake, master N (N=0,1).
REQ-006 mN_req_len  in  LEN_W  beat count; mN_req_mask  in  4  byte lanes; mN_req_addr  in  DATA_W; mN_req_we  in  1  write when high.
REQ-007 mN_write_valid  in  1; mN_write_data  in  DATA_W  write beat, one beat per cycle when valid.
REQ-008 mN_read_valid  out  1; mN_read_data  out  DATA_W; mN_read_ack  in  1  read beat handshake.
REQ-009 s_req_valid/ready, s_req_len, s_req_mask, s_req_addr, s_req_we, s_write_valid, s_write_data, s_read_valid (in), s_read_data (in), s_read_ack (out) SHALL mirror the master port set toward the memory side.
REQ-010 grant  out  1  index of the current owner; busy  out  1  high outside IDLE.

Function
- REQ-011 FSM states: IDLE, REQ, DATA.
- REQ-012 IDLE: if any mN_req_valid, the arbiter SHALL latch the winner into grant and move to REQ on the next edge. It SHALL NOT forward anything during IDLE.
- REQ-013 REQ: s_req_* SHALL combinationally equal the granted master's fields. mG_req_ready SHALL equal s_req_ready. The non-granted master's req_ready SHALL be 0.
- REQ-014 REQ: when s_req_valid & s_req_ready, the arbiter SHALL latch len (a value of 0 is treated as 1) and we, clear the beat counter, and move to DATA.
- REQ-015 REQ: if mG_req_valid drops before the handshake, the FSM SHALL return to IDLE with no beat counted.
- REQ-016 DATA, read: s_read_valid/s_read_data SHALL be routed to mG_read_*, and s_read_ack = mG_read_ack. Each cycle where s_read_valid & s_read_ack are both high counts one beat.
- REQ-017 DATA, write: s_write_valid/s_write_data SHALL equal mG_write_*. Each mG_write_valid counts one beat.
- REQ-018 When a counted beat makes count == latched len, the FSM SHALL enter IDLE on that edge. The earliest next grant is the following cycle, so the minimum request-to-request gap is 1 IDLE cycle.
- REQ-019 The non-granted master SHALL see read_valid=0 and read_data=0 at all times. Its write_valid SHALL be ignored.
- REQ-020 Outside DATA: s_write_valid=0 and s_read_ack=0. Outside REQ: s_req_valid=0.
- REQ-021 Simultaneous requests in IDLE SHALL be resolved per REQ-026/027.
- REQ-022 Beats arriving while in IDLE or REQ SHALL be dropped and not counted.

Reset
- REQ-023 While rst_ni=0 at a clock edge, the following SHALL hold: state=IDLE, grant=0, busy=0, beat counter=0, priority pointer=0, all valid/ready/ack outputs=0.
- REQ-024 Data outputs SHALL be 0 during reset.
- REQ-025 Reset asserted mid-burst SHALL abandon the burst immediately with no further beats counted. The memory side is reset by the same rst_ni.

Configuration
- REQ-026 With MEM_ARB_RR_EN defined: round-robin. After each completed or abandoned burst, the pointer SHALL move to the other master. On simultaneous requests, the master the pointer selects wins.
- REQ-027 Without MEM_ARB_RR_EN: fixed priority, with m0 always winning simultaneous requests. No pointer register SHALL be present.

Structure
- REQ-028 The shared package SHALL hold the FSM state encoding (IDLE=0, REQ=1, DATA=2) and the default DATA_W/LEN_W constants.
- REQ-029 One sub-module, mem_arb_pick, SHALL hold the combinational winner selection (inputs: two valids and the pointer; output: index). All remaining logic stays in mem_arbiter.

Verification
- REQ-030 m0 reads at addr 0x1000, len 1; s_req_ready is high in the first REQ cycle; one read beat 0xDEADBEEF arrives. Required response: m0_read_data=0xDEADBEEF, IDLE 1 cycle after the ack, m1 sees no read_valid.
- REQ-031 Both masters request in the same cycle, each len 4 write, RR enabled. Required response: m0 is served first with 4 beats counted, then m1 is granted after 1 IDLE cycle. With RR disabled and m0 re-requesting, m0 wins again.
- REQ-032 m1 requests len 0 read. Required response: treated as 1 beat, and the FSM returns to IDLE after exactly 1 acked beat.
- REQ-033 m0 drops req_valid in REQ while s_req_ready stays 0. Required response: back to IDLE, s_req_valid=0, and a pending m1 is granted next.
- REQ-034 rst_ni pulled low after beat 2 of a len 4 read. Required response: all outputs 0 the next cycle; after release, a new m1 len 1 write completes normally.
- REQ-035 s_read_valid is high while m0_read_ack stays low for 3 cycles. Required response: no beat is counted until the ack arrives, and count reaches len exactly once per acked beat.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encoding and default widths shared by the mem_arbiter files.
package mem_arbiter_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2} state_t;
endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: two-way winner select; ptr breaks a tie, otherwise the lone requester wins.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic index
);
    always_comb index = (valid0 && valid1) ? ptr : valid1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two masters share one memory port via an IDLE/REQ/DATA burst FSM.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [LEN_W-1:0]  m0_req_len,
    input  logic [3:0]        m0_req_mask,
    input  logic [DATA_W-1:0] m0_req_addr,
    input  logic              m0_req_we,
    input  logic              m0_write_valid,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic              m0_read_valid,
    output logic [DATA_W-1:0] m0_read_data,
    input  logic              m0_read_ack,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [LEN_W-1:0]  m1_req_len,
    input  logic [3:0]        m1_req_mask,
    input  logic [DATA_W-1:0] m1_req_addr,
    input  logic              m1_req_we,
    input  logic              m1_write_valid,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic              m1_read_valid,
    output logic [DATA_W-1:0] m1_read_data,
    input  logic              m1_read_ack,
    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [LEN_W-1:0]  s_req_len,
    output logic [3:0]        s_req_mask,
    output logic [DATA_W-1:0] s_req_addr,
    output logic              s_req_we,
    output logic              s_write_valid,
    output logic [DATA_W-1:0] s_write_data,
    input  logic              s_read_valid,
    input  logic [DATA_W-1:0] s_read_data,
    output logic              s_read_ack,
    output logic              grant,
    output logic              busy
);
    state_t           state;
    logic [LEN_W-1:0] len_q, cnt, cnt_nx;
    logic             we_q, pick, ptr, in_req, in_data, rd, wr, g_req_valid, beat, last, drop;

    mem_arb_pick u_pick (.valid0(m0_req_valid), .valid1(m1_req_valid), .ptr(ptr), .index(pick));

    // Forwarding is gated by rst_ni too, so every output is already 0 while reset is held.
    assign in_req      = rst_ni && state == REQ;
    assign in_data     = rst_ni && state == DATA;
    assign rd          = in_data && !we_q;
    assign wr          = in_data && we_q;
    assign g_req_valid = grant ? m1_req_valid : m0_req_valid;

    assign s_req_valid  = in_req && g_req_valid;
    assign s_req_len    = in_req ? (grant ? m1_req_len  : m0_req_len)  : '0;
    assign s_req_mask   = in_req ? (grant ? m1_req_mask : m0_req_mask) : '0;
    assign s_req_addr   = in_req ? (grant ? m1_req_addr : m0_req_addr) : '0;
    assign s_req_we     = in_req && (grant ? m1_req_we : m0_req_we);
    assign m0_req_ready = in_req && !grant && s_req_ready;
    assign m1_req_ready = in_req && grant && s_req_ready;

    assign s_write_valid = wr && (grant ? m1_write_valid : m0_write_valid);
    assign s_write_data  = wr ? (grant ? m1_write_data : m0_write_data) : '0;
    assign s_read_ack    = rd && (grant ? m1_read_ack : m0_read_ack);
    assign m0_read_valid = rd && !grant && s_read_valid;
    assign m1_read_valid = rd && grant && s_read_valid;
    assign m0_read_data  = (rd && !grant) ? s_read_data : '0;
    assign m1_read_data  = (rd && grant) ? s_read_data : '0;

    assign beat   = s_write_valid || (s_read_valid && s_read_ack);
    assign cnt_nx = cnt + 1'b1;
    assign last   = in_data && beat && cnt_nx == len_q;
    assign drop   = in_req && !g_req_valid;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            ptr <= 1'b0;
        else if (last || drop)
            ptr <= ~grant;
    end
`else
    assign ptr = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            grant <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
            we_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (m0_req_valid || m1_req_valid) begin
                    grant <= pick;
                    state <= REQ;
                    busy  <= 1'b1;
                end
                REQ: if (!g_req_valid) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (s_req_ready) begin
                    len_q <= (s_req_len == '0) ? LEN_W'(1) : s_req_len;
                    we_q  <= s_req_we;
                    cnt   <= '0;
                    state <= DATA;
                end
                DATA: if (beat) begin
                    cnt <= cnt_nx;
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random bursts checked against a transaction-level model.
module tb_mem_arbiter;
    logic        clk_i = 0, rst_ni = 0;
    logic        rq[2], wem[2], wv[2], ack[2], rr[2], rv[2];
    logic [2:0]  ln[2];
    logic [3:0]  mk[2];
    logic [31:0] ad[2], wd[2], rdat[2];
    logic        s_req_valid, s_req_ready, s_req_we, s_write_valid, s_read_valid, s_read_ack, grant, busy;
    logic [2:0]  s_req_len;
    logic [3:0]  s_req_mask;
    logic [31:0] s_req_addr, s_write_data, s_read_data;
    int          total = 0, bad = 0;
    bit          ptr_m = 0;

    mem_arbiter #(.DATA_W(32), .LEN_W(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_valid(rq[0]), .m0_req_ready(rr[0]), .m0_req_len(ln[0]), .m0_req_mask(mk[0]),
        .m0_req_addr(ad[0]), .m0_req_we(wem[0]), .m0_write_valid(wv[0]), .m0_write_data(wd[0]),
        .m0_read_valid(rv[0]), .m0_read_data(rdat[0]), .m0_read_ack(ack[0]),
        .m1_req_valid(rq[1]), .m1_req_ready(rr[1]), .m1_req_len(ln[1]), .m1_req_mask(mk[1]),
        .m1_req_addr(ad[1]), .m1_req_we(wem[1]), .m1_write_valid(wv[1]), .m1_write_data(wd[1]),
        .m1_read_valid(rv[1]), .m1_read_data(rdat[1]), .m1_read_ack(ack[1]),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_len(s_req_len),
        .s_req_mask(s_req_mask), .s_req_addr(s_req_addr), .s_req_we(s_req_we),
        .s_write_valid(s_write_valid), .s_write_data(s_write_data), .s_read_valid(s_read_valid),
        .s_read_data(s_read_data), .s_read_ack(s_read_ack), .grant(grant), .busy(busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0; wv[i] = 0; ack[i] = 0; wd[i] = 0; ln[i] = 0; mk[i] = 0; ad[i] = 0; wem[i] = 0;
        end
        s_req_ready = 0; s_read_valid = 0; s_read_data = 0;
    endtask

    // Tie-break rule: pointer under round-robin, m0 under fixed priority.
    function automatic bit winner(input bit v0, input bit v1);
`ifdef MEM_ARB_RR_EN
        return (v0 && v1) ? ptr_m : v1;
`else
        return (v0 && v1) ? 1'b0 : v1;
`endif
    endfunction

    task automatic round(input bit v0, input bit v1, input logic [2:0] l0, input logic [2:0] l1,
                         input bit w0, input bit w1, input int stall, input bit drop);
        bit w;
        int n, got, cyc;
        rq[0] = v0; rq[1] = v1; ln[0] = l0; ln[1] = l1; wem[0] = w0; wem[1] = w1;
        for (int i = 0; i < 2; i++) begin ad[i] = $urandom; mk[i] = 4'($urandom); end
        w = winner(v0, v1);
        #1;
        chk("idle_no_fwd", s_req_valid, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("grant", grant, w);
        chk("busy_req", busy, 1);
        chk("req_valid", s_req_valid, 1);
        chk("req_addr", s_req_addr, ad[w]);
        chk("req_len", s_req_len, ln[w]);
        chk("req_mask", s_req_mask, mk[w]);
        chk("req_we", s_req_we, wem[w]);
        for (int i = 0; i < stall; i++) begin
            s_read_valid = 1; ack[w] = 1; wv[w] = 1;
            #1;
            chk("req_drop_wr", s_write_valid, 0);
            chk("req_drop_ack", s_read_ack, 0);
            chk("req_ready_lo", rr[w], 0);
            tick();
        end
        s_read_valid = 0; ack[w] = 0; wv[w] = 0;
        if (drop) begin
            rq[w] = 0;
            #1;
            chk("drop_req_valid", s_req_valid, 0);
            tick();
            chk("drop_idle", busy, 0);
            ptr_m = !w;
            return;
        end
        s_req_ready = 1;
        #1;
        chk("winner_ready", rr[w], 1);
        chk("loser_ready", rr[!w], 0);
        tick();
        s_req_ready = 0; rq[w] = 0;
        n = (ln[w] == 0) ? 1 : int'(ln[w]);
        got = 0; cyc = 0;
        while (got < n && cyc < 64) begin
            chk("busy_data", busy, 1);
            if (wem[w]) begin
                wv[w] = 1'($urandom_range(0, 1)); wd[w] = $urandom;
                wv[!w] = 1'($urandom_range(0, 1)); wd[!w] = $urandom;
                #1;
                chk("wr_valid", s_write_valid, wv[w]);
                chk("wr_data", s_write_data, wd[w]);
                if (wv[w]) got++;
            end else begin
                s_read_valid = 1'($urandom_range(0, 1)); s_read_data = $urandom;
                ack[w] = 1'($urandom_range(0, 1)); ack[!w] = 1'($urandom_range(0, 1));
                #1;
                chk("rd_valid", rv[w], s_read_valid);
                chk("rd_data", rdat[w], s_read_data);
                chk("loser_rv", rv[!w], 0);
                chk("loser_rd", rdat[!w], 0);
                chk("rd_ack", s_read_ack, ack[w]);
                if (s_read_valid && ack[w]) got++;
            end
            cyc++;
            tick();
        end
        if (cyc >= 64) begin
            total++; bad++;
            $error("FAIL beat_budget observed=%0d expected=%0d", got, n);
        end
        wv[0] = 0; wv[1] = 0; ack[0] = 0; ack[1] = 0; s_read_valid = 0;
        #1;
        chk("done_idle", busy, 0);
        ptr_m = !w;
    endtask

    initial begin
        quiet();
        rst_ni = 0; rq[0] = 1; rq[1] = 1; s_req_ready = 1; s_read_valid = 1; s_read_data = 32'hA5A5A5A5;
        ack[0] = 1; ack[1] = 1; wv[0] = 1; ad[0] = 32'h1234;
        tick(); tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", s_req_valid, 0);
        chk("rst_ready0", rr[0], 0);
        chk("rst_rv0", rv[0], 0);
        chk("rst_rd0", rdat[0], 0);
        chk("rst_ack", s_read_ack, 0);
        chk("rst_addr", s_req_addr, 0);
        chk("rst_wv", s_write_valid, 0);
        quiet();
        rst_ni = 1;
        tick();

        // Simultaneous len-4 writes, then both request again.
        round(1, 1, 4, 4, 1, 1, 0, 0);
        round(1, 1, 4, 4, 1, 1, 1, 0);
        quiet();

        // m0 single-beat read of 0xDEADBEEF.
        rq[0] = 1; ln[0] = 1; ad[0] = 32'h1000; s_req_ready = 1;
        tick();
        chk("rd1_grant", grant, 0);
        chk("rd1_addr", s_req_addr, 32'h1000);
        chk("rd1_ready0", rr[0], 1);
        chk("rd1_ready1", rr[1], 0);
        tick();
        rq[0] = 0; s_req_ready = 0; s_read_valid = 1; s_read_data = 32'hDEADBEEF; ack[0] = 1;
        #1;
        chk("rd1_data", rdat[0], 32'hDEADBEEF);
        chk("rd1_rv1", rv[1], 0);
        chk("rd1_ack", s_read_ack, 1);
        tick();
        chk("rd1_idle", busy, 0);
        ptr_m = 1;
        quiet();

        // Zero length read counts as one beat.
        round(0, 1, 0, 0, 0, 0, 1, 0);
        // m0 abandons in REQ, then m1 is granted.
        round(1, 0, 2, 0, 0, 0, 2, 1);
        round(0, 1, 0, 2, 0, 1, 0, 0);
        quiet();

        // Read beats held off by a late ack.
        rq[0] = 1; ln[0] = 2;
        tick();
        s_req_ready = 1;
        tick();
        rq[0] = 0; s_req_ready = 0; s_read_valid = 1; s_read_data = 32'h55AA0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rv", rv[0], 1);
            chk("stall_ack", s_read_ack, 0);
            tick();
            chk("stall_busy", busy, 1);
        end
        ack[0] = 1;
        tick();
        chk("ack1_busy", busy, 1);
        tick();
        chk("ack2_idle", busy, 0);
        ptr_m = 1;
        quiet();

        // Reset after two beats of a len-4 read.
        rq[0] = 1; ln[0] = 4;
        tick();
        s_req_ready = 1;
        tick();
        rq[0] = 0; s_req_ready = 0; s_read_valid = 1; s_read_data = 32'h0BADF00D; ack[0] = 1;
        tick(); tick();
        rst_ni = 0; rq[1] = 1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_rv0", rv[0], 0);
        chk("mid_rst_rd0", rdat[0], 0);
        chk("mid_rst_ack", s_read_ack, 0);
        chk("mid_rst_req", s_req_valid, 0);
        rst_ni = 1; ptr_m = 0;
        quiet();
        round(0, 1, 1, 1, 1, 1, 0, 0);
        quiet();

        for (int k = 0; k < 40; k++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            round(r[0], r[1], 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
            quiet();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
